mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the pipelined processor.
- Takes the EX/MEM bundle and runs load/store transactions on a req/ack data-memory port, stalling upstream while a transaction is in flight.
- Registers everything the write-back mux stage consumes: ALU result, memory data, PC/branch, jump address, ReadData1 and the WB control bits.

Parameters:
- NBits, 32, datapath/address width.
- TIMEOUT, 255, max cycles waiting for mem_Ack before abort (must be at least 1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- in_Valid  in  1  EX/MEM slot holds a real instruction.
- in_Flush  in  1  kill current/incoming instruction.
- in_MemRead  in  1  load.
- in_MemWrite  in  1  store.
- in_WBCtrl  in  5  {RegWrite, RegisterOrPC, JumpControl, ALUMemOrPC, MemtoReg}.
- in_WriteReg  in  5  destination register.
- in_ALUResult  in  NBits  ALU result / memory address.
- in_StoreData  in  NBits  store data.
- in_PCOrBranch  in  NBits  next sequential or branch PC.
- in_JumpAddress  in  NBits  jump target.
- in_ReadData1  in  NBits  rs value (jr).
- mem_Req  out  1  memory request.
- mem_We  out  1  1 = write.
- mem_Addr  out  NBits  address.
- mem_WData  out  NBits  write data.
- mem_Ack  in  1  transaction complete; mem_RData valid this cycle.
- mem_RData  in  NBits  read data.
- out_Stall  out  1  upstream must hold EX/MEM.
- out_Valid  out  1  MEM/WB slot valid.
- out_WBCtrl  out  5  registered WB controls; forced 0 on bubble.
- out_WriteReg  out  5  registered destination.
- out_ALUResult, out_MemoryData, out_PCOrBranch, out_JumpAddress, out_ReadData1  out  NBits each  registered to the write-back stage.
- out_MemError  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, all outputs 0, kill flag and counter cleared.
- A reset that arrives during ACCESS abandons the transaction; mem_Req is 0 after that edge.
- memop = in_Valid & (in_MemRead | in_MemWrite).
- IDLE, non-memop or flushed instruction:
  - MEM/WB loads on the next edge (1-cycle latency).
  - out_Valid = in_Valid & ~in_Flush.
  - out_WBCtrl = 0 when not valid.
  - out_MemoryData = 0.
- IDLE, memop & ~in_Flush:
  - Latch address, data, we and all pass-through fields; go to ACCESS.
  - mem_Req goes high on the next edge.
  - MEM/WB loads a bubble (out_Valid=0).
  - out_Stall is combinational 1 this cycle.
- ACCESS:
  - mem_Req=1; mem_Addr, mem_WData and mem_We stay constant until the ack cycle inclusive.
  - out_Stall=1 except in the mem_Ack cycle.
  - mem_Ack is sampled only in ACCESS and ignored elsewhere.
- ACCESS, mem_Ack=1:
  - Next edge: mem_Req=0 and MEM/WB loads the latched fields.
  - out_MemoryData = mem_RData for a load, 0 for a store.
  - out_Valid = ~kill; state returns to IDLE.
  - out_Stall=0 in the ack cycle, so upstream advances and the next instruction is evaluated from IDLE on the following cycle (one bubble between back-to-back memops).
- in_Flush during ACCESS:
  - The transaction is not aborted (stores still commit).
  - Kill flag is set; the result retires as a bubble.
- Timeout:
  - Counter increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT: drop mem_Req, load a bubble, pulse out_MemError, return to IDLE.
  - Ack arriving on the same cycle as the TIMEOUT count wins (normal completion).
- Widths: counter is $clog2(TIMEOUT+1) bits. No arithmetic on the datapath.

Decomposition:
- Shared package holds:
  - WB control bit indices (WB_REGWRITE=4 … WB_MEMTOREG=0) and WB_CTRL_W=5.
  - State encoding (IDLE, ACCESS).
  - REG_ADDR_W=5.
- One sub-module, mem_wb_register: the MEM/WB flop bank with load/bubble inputs and synchronous active-low reset.
- The FSM, counter and latches live in the top module.

Test Plan:
- Reset: hold reset=0 3 cycles mid-ACCESS -> all outputs 0, mem_Req=0, state IDLE.
- ALU op: in_ALUResult=0x10, in_WBCtrl=5'b10000 -> next cycle out_Valid=1, out_ALUResult=0x10, out_Stall never asserted.
- Load with 2-cycle memory: addr 0x40, mem_RData=0xDEADBEEF on ack -> mem_Req high 2 cycles, out_Stall high until the ack cycle, then out_MemoryData=0xDEADBEEF, out_Valid=1.
- Store then load back-to-back -> mem_We=1 then 0, exactly one bubble between them, store retires with out_MemoryData=0.
- Flush during ACCESS of a load -> access completes, out_Valid=0, out_WBCtrl=0.
- TIMEOUT=4, never ack -> mem_Req drops after 4 cycles, out_MemError pulses 1 cycle, bubble retires, next ALU op passes normally.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory-access / MEM-WB stage:
// WB control bit positions, register address width and the
// memory FSM state encoding.
package mem_wb_stage_pkg;

   localparam int unsigned WB_CTRL_W       = 5;
   localparam int unsigned REG_ADDR_W      = 5;

   // Bit positions inside the {RegWrite, RegisterOrPC, JumpControl,
   // ALUMemOrPC, MemtoReg} write-back control bundle.
   localparam int unsigned WB_REGWRITE     = 4;
   localparam int unsigned WB_REGISTERORPC = 3;
   localparam int unsigned WB_JUMPCONTROL  = 2;
   localparam int unsigned WB_ALUMEMORPC   = 1;
   localparam int unsigned WB_MEMTOREG     = 0;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register bank.
//   clk, reset    : clock, synchronous active-low reset
//   bubble_i      : clear valid and WB controls (has priority over load_i)
//   load_i        : capture all d_* fields
//   d_* / q_*     : fields headed for the write-back mux stage
import mem_wb_stage_pkg::*;

module mem_wb_register #(
   parameter int unsigned NBits = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  bubble_i,
   input  logic                  load_i,
   input  logic                  d_valid,
   input  logic [WB_CTRL_W-1:0]  d_wbctrl,
   input  logic [REG_ADDR_W-1:0] d_writereg,
   input  logic [NBits-1:0]      d_aluresult,
   input  logic [NBits-1:0]      d_memorydata,
   input  logic [NBits-1:0]      d_pcorbranch,
   input  logic [NBits-1:0]      d_jumpaddress,
   input  logic [NBits-1:0]      d_readdata1,
   output logic                  q_valid,
   output logic [WB_CTRL_W-1:0]  q_wbctrl,
   output logic [REG_ADDR_W-1:0] q_writereg,
   output logic [NBits-1:0]      q_aluresult,
   output logic [NBits-1:0]      q_memorydata,
   output logic [NBits-1:0]      q_pcorbranch,
   output logic [NBits-1:0]      q_jumpaddress,
   output logic [NBits-1:0]      q_readdata1
);

   logic                  valid_q,   valid_d;
   logic [WB_CTRL_W-1:0]  wbctrl_q,  wbctrl_d;
   logic [REG_ADDR_W-1:0] wreg_q,    wreg_d;
   logic [NBits-1:0]      alu_q,     alu_d;
   logic [NBits-1:0]      mdata_q,   mdata_d;
   logic [NBits-1:0]      pc_q,      pc_d;
   logic [NBits-1:0]      jaddr_q,   jaddr_d;
   logic [NBits-1:0]      rd1_q,     rd1_d;

   always_comb begin
      valid_d  = valid_q;
      wbctrl_d = wbctrl_q;
      wreg_d   = wreg_q;
      alu_d    = alu_q;
      mdata_d  = mdata_q;
      pc_d     = pc_q;
      jaddr_d  = jaddr_q;
      rd1_d    = rd1_q;
      if (bubble_i) begin
         // A bubble only needs to neutralise the slot; datapath fields hold.
         valid_d  = 1'b0;
         wbctrl_d = '0;
      end else if (load_i) begin
         valid_d  = d_valid;
         wbctrl_d = d_wbctrl;
         wreg_d   = d_writereg;
         alu_d    = d_aluresult;
         mdata_d  = d_memorydata;
         pc_d     = d_pcorbranch;
         jaddr_d  = d_jumpaddress;
         rd1_d    = d_readdata1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q  <= 1'b0;
         wbctrl_q <= '0;
         wreg_q   <= '0;
         alu_q    <= '0;
         mdata_q  <= '0;
         pc_q     <= '0;
         jaddr_q  <= '0;
         rd1_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         wbctrl_q <= wbctrl_d;
         wreg_q   <= wreg_d;
         alu_q    <= alu_d;
         mdata_q  <= mdata_d;
         pc_q     <= pc_d;
         jaddr_q  <= jaddr_d;
         rd1_q    <= rd1_d;
      end
   end

   assign q_valid       = valid_q;
   assign q_wbctrl      = wbctrl_q;
   assign q_writereg    = wreg_q;
   assign q_aluresult   = alu_q;
   assign q_memorydata  = mdata_q;
   assign q_pcorbranch  = pc_q;
   assign q_jumpaddress = jaddr_q;
   assign q_readdata1   = rd1_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB pipeline register.
//   in_*      : EX/MEM bundle (valid, flush, load/store, WB controls, data)
//   mem_*     : req/ack data-memory port, request held until ack or timeout
//   out_Stall : combinational hold request to upstream stages
//   out_*     : registered MEM/WB fields for the write-back mux stage
//   out_MemError : one-cycle pulse when a transaction times out
import mem_wb_stage_pkg::*;

module mem_wb_stage #(
   parameter int unsigned NBits   = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_Valid,
   input  logic                  in_Flush,
   input  logic                  in_MemRead,
   input  logic                  in_MemWrite,
   input  logic [WB_CTRL_W-1:0]  in_WBCtrl,
   input  logic [REG_ADDR_W-1:0] in_WriteReg,
   input  logic [NBits-1:0]      in_ALUResult,
   input  logic [NBits-1:0]      in_StoreData,
   input  logic [NBits-1:0]      in_PCOrBranch,
   input  logic [NBits-1:0]      in_JumpAddress,
   input  logic [NBits-1:0]      in_ReadData1,
   output logic                  mem_Req,
   output logic                  mem_We,
   output logic [NBits-1:0]      mem_Addr,
   output logic [NBits-1:0]      mem_WData,
   input  logic                  mem_Ack,
   input  logic [NBits-1:0]      mem_RData,
   output logic                  out_Stall,
   output logic                  out_Valid,
   output logic [WB_CTRL_W-1:0]  out_WBCtrl,
   output logic [REG_ADDR_W-1:0] out_WriteReg,
   output logic [NBits-1:0]      out_ALUResult,
   output logic [NBits-1:0]      out_MemoryData,
   output logic [NBits-1:0]      out_PCOrBranch,
   output logic [NBits-1:0]      out_JumpAddress,
   output logic [NBits-1:0]      out_ReadData1,
   output logic                  out_MemError
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   mem_state_e            state_q, state_d;
   logic                  req_q,   req_d;
   logic                  we_q,    we_d;
   logic                  kill_q,  kill_d;
   logic                  err_q,   err_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;
   logic [WB_CTRL_W-1:0]  wb_q,    wb_d;
   logic [REG_ADDR_W-1:0] wreg_q,  wreg_d;
   logic [NBits-1:0]      addr_q,  addr_d;
   logic [NBits-1:0]      sdata_q, sdata_d;
   logic [NBits-1:0]      pc_q,    pc_d;
   logic [NBits-1:0]      jaddr_q, jaddr_d;
   logic [NBits-1:0]      rd1_q,   rd1_d;

   logic                  memop;
   logic                  stall;
   logic                  r_bubble, r_load, r_valid;
   logic [WB_CTRL_W-1:0]  r_wbctrl;
   logic [REG_ADDR_W-1:0] r_wreg;
   logic [NBits-1:0]      r_alu, r_mdata, r_pc, r_jaddr, r_rd1;

   assign memop = in_Valid & (in_MemRead | in_MemWrite);

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      we_d     = we_q;
      kill_d   = kill_q;
      err_d    = 1'b0;
      cnt_d    = cnt_q;
      wb_d     = wb_q;
      wreg_d   = wreg_q;
      addr_d   = addr_q;
      sdata_d  = sdata_q;
      pc_d     = pc_q;
      jaddr_d  = jaddr_q;
      rd1_d    = rd1_q;
      stall    = 1'b0;
      r_bubble = 1'b0;
      r_load   = 1'b0;
      r_valid  = 1'b0;
      r_wbctrl = '0;
      r_wreg   = in_WriteReg;
      r_alu    = in_ALUResult;
      r_mdata  = '0;
      r_pc     = in_PCOrBranch;
      r_jaddr  = in_JumpAddress;
      r_rd1    = in_ReadData1;

      unique case (state_q)
         ST_IDLE: begin
            if (memop && !in_Flush) begin
               state_d  = ST_ACCESS;
               req_d    = 1'b1;
               we_d     = in_MemWrite;
               kill_d   = 1'b0;
               cnt_d    = '0;
               wb_d     = in_WBCtrl;
               wreg_d   = in_WriteReg;
               addr_d   = in_ALUResult;
               sdata_d  = in_StoreData;
               pc_d     = in_PCOrBranch;
               jaddr_d  = in_JumpAddress;
               rd1_d    = in_ReadData1;
               stall    = 1'b1;
               r_bubble = 1'b1;
            end else begin
               r_load   = 1'b1;
               r_valid  = in_Valid & ~in_Flush;
               r_wbctrl = r_valid ? in_WBCtrl : '0;
            end
         end
         ST_ACCESS: begin
            if (mem_Ack) begin
               // Ack beats a simultaneous timeout; a flush seen now or
               // earlier still lets the access finish but retires a bubble.
               state_d  = ST_IDLE;
               req_d    = 1'b0;
               r_load   = 1'b1;
               r_valid  = ~(kill_q | in_Flush);
               r_wbctrl = r_valid ? wb_q : '0;
               r_wreg   = wreg_q;
               r_alu    = addr_q;
               r_mdata  = we_q ? '0 : mem_RData;
               r_pc     = pc_q;
               r_jaddr  = jaddr_q;
               r_rd1    = rd1_q;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d  = ST_IDLE;
               req_d    = 1'b0;
               err_d    = 1'b1;
               stall    = 1'b1;
               r_bubble = 1'b1;
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
               kill_d   = kill_q | in_Flush;
               stall    = 1'b1;
               r_bubble = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         kill_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         wb_q    <= '0;
         wreg_q  <= '0;
         addr_q  <= '0;
         sdata_q <= '0;
         pc_q    <= '0;
         jaddr_q <= '0;
         rd1_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         kill_q  <= kill_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         wb_q    <= wb_d;
         wreg_q  <= wreg_d;
         addr_q  <= addr_d;
         sdata_q <= sdata_d;
         pc_q    <= pc_d;
         jaddr_q <= jaddr_d;
         rd1_q   <= rd1_d;
      end
   end

   assign mem_Req      = req_q;
   assign mem_We       = we_q;
   assign mem_Addr     = addr_q;
   assign mem_WData    = sdata_q;
   assign out_Stall    = stall;
   assign out_MemError = err_q;

   mem_wb_register #(
      .NBits (NBits)
   ) u_mem_wb_register (
      .clk           (clk),
      .reset         (reset),
      .bubble_i      (r_bubble),
      .load_i        (r_load),
      .d_valid       (r_valid),
      .d_wbctrl      (r_wbctrl),
      .d_writereg    (r_wreg),
      .d_aluresult   (r_alu),
      .d_memorydata  (r_mdata),
      .d_pcorbranch  (r_pc),
      .d_jumpaddress (r_jaddr),
      .d_readdata1   (r_rd1),
      .q_valid       (out_Valid),
      .q_wbctrl      (out_WBCtrl),
      .q_writereg    (out_WriteReg),
      .q_aluresult   (out_ALUResult),
      .q_memorydata  (out_MemoryData),
      .q_pcorbranch  (out_PCOrBranch),
      .q_jumpaddress (out_JumpAddress),
      .q_readdata1   (out_ReadData1)
   );

endmodule
